// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
package mult_div_unit_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned DEF_MULT_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mdState_t;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hiLo_t;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the HI/LO result pair.
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              isMU,
    input  logic              isSigned,
    input  logic [DATA_W-1:0] HI,
    input  logic [DATA_W-1:0] LO,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo
);

    logic [2*DATA_W-1:0] extA;
    logic [2*DATA_W-1:0] extB;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   magA;
    logic [DATA_W-1:0]   magB;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;
    logic                negQ;
    logic                negR;

    // Divide on magnitudes then restore signs: truncation toward zero, and
    // 0x80000000 / -1 falls out naturally as 0x80000000 with remainder 0.
    always_comb begin
        res_hi = HI;
        res_lo = LO;
        quo    = '0;
        rem    = '0;
        extA   = isSigned ? {{DATA_W{A[DATA_W-1]}}, A} : {{DATA_W{1'b0}}, A};
        extB   = isSigned ? {{DATA_W{B[DATA_W-1]}}, B} : {{DATA_W{1'b0}}, B};
        prod   = extA * extB;
        negR   = isSigned & A[DATA_W-1];
        negQ   = isSigned & (A[DATA_W-1] ^ B[DATA_W-1]);
        magA   = negR ? DATA_W'(-A) : A;
        magB   = (isSigned & B[DATA_W-1]) ? DATA_W'(-B) : B;
        if (B != '0) begin
            quo = magA / magB;
            rem = magA % magB;
        end
        if (isMU) begin
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
        end else if (B != '0) begin
            res_lo = negQ ? DATA_W'(-quo) : quo;
            res_hi = negR ? DATA_W'(-rem) : rem;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO and a busy flag for hazard stalls.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              isMU,
    input  logic              isDI,
    input  logic              isSigned,
    input  logic              WriteHL,
    input  logic              WriteHi,
    input  logic              ReadHi,
    input  logic              req,
    output logic              busy,
    output logic [DATA_W-1:0] HLOut
);

    mdState_t          state;
    logic [CNT_W-1:0]  counter;
    hiLo_t             hl;
    hiLo_t             pend;
    logic [DATA_W-1:0] resHi;
    logic [DATA_W-1:0] resLo;
    logic              start;
    logic              writeOk;

    assign start   = (isMU | isDI) & ~req & (state == IDLE);
    assign writeOk = WriteHL & ~req & (state == IDLE);
    assign HLOut   = ReadHi ? hl.hi : hl.lo;

    md_arith u_arith (
        .A        (A),
        .B        (B),
        .isMU     (isMU),
        .isSigned (isSigned),
        .HI       (hl.hi),
        .LO       (hl.lo),
        .res_hi   (resHi),
        .res_lo   (resLo)
    );

    // Result is captured at start and held in pend until the final busy edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            hl      <= '0;
            pend    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend.hi <= resHi;
                        pend.lo <= resLo;
                        counter <= isMU ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state   <= RUN;
                        busy    <= 1'b1;
                    end else if (writeOk) begin
                        if (WriteHi) hl.hi <= A;
                        else         hl.lo <= A;
                    end
                end
                RUN: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        hl    <= pend;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit against an arithmetic HI/LO reference model.
module tb_mult_div_unit;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] A, B;
    logic        isMU, isDI, isSigned, WriteHL, WriteHi, ReadHi, req;
    logic        busy;
    logic [31:0] HLOut;

    int errors = 0;
    int checks = 0;

    logic [31:0] mHi, mLo;

    mult_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .A        (A),
        .B        (B),
        .isMU     (isMU),
        .isDI     (isDI),
        .isSigned (isSigned),
        .WriteHL  (WriteHL),
        .WriteHi  (WriteHi),
        .ReadHi   (ReadHi),
        .req      (req),
        .busy     (busy),
        .HLOut    (HLOut)
    );

    always #5 clk = ~clk;

    // Hazard logic must never issue an MD op while busy
    always @(posedge clk) begin
        if (reset_n === 1'b1 && busy === 1'b1 && (isMU || isDI || WriteHL)) begin
            errors++;
            $display("FAIL illegal_issue: MD op issued while busy at %0t", $time);
        end
    end

    // Reference: plain 64-bit arithmetic on the architectural definition
    task automatic model(input bit mul, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eHi, output logic [31:0] eLo);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (sgn) begin sa = $signed(a); sb = $signed(b); end
        else     begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); end
        eHi = mHi;
        eLo = mLo;
        if (mul) begin
            p = 64'(sa * sb);
            eHi = p[63:32];
            eLo = p[31:0];
        end else if (b != 0) begin
            q = sa / sb;
            r = sa % sb;
            eLo = q[31:0];
            eHi = r[31:0];
        end
    endtask

    // Drives one start at the next edge, counts busy cycles, reads HI/LO afterwards
    task automatic run_op(input bit mul, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                          input bit reqInRun, output int nBusy, output logic [31:0] lastOldLo,
                          output logic [31:0] oHi, output logic [31:0] oLo);
        isMU = mul; isDI = !mul; isSigned = sgn; A = a; B = b;
        @(posedge clk);
        @(negedge clk);
        isMU = 0; isDI = 0; A = $urandom; B = $urandom;
        nBusy = 0;
        lastOldLo = 'x;
        while (busy === 1'b1 && nBusy < 20) begin
            nBusy++;
            ReadHi = 0;
            #1 lastOldLo = HLOut;
            req = reqInRun;
            @(negedge clk);
        end
        req = 0;
        ReadHi = 1;
        #1 oHi = HLOut;
        ReadHi = 0;
        #1 oLo = HLOut;
    endtask

    task automatic write_hl(input bit hi, input logic [31:0] val);
        WriteHL = 1; WriteHi = hi; A = val;
        @(posedge clk);
        @(negedge clk);
        WriteHL = 0;
        if (hi) mHi = val; else mLo = val;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1;
        @(negedge clk);
        ReadHi = 1;
        #1 checks++;
        if (HLOut !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", HLOut); end
        ReadHi = 0;
        #1 checks++;
        if (HLOut !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", HLOut); end
        mHi = 0; mLo = 0;
    endtask

    task automatic test_op(input string name, input bit mul, input bit sgn,
                           input logic [31:0] a, input logic [31:0] b, input bit reqInRun);
        logic [31:0] eHi, eLo, oldLo, gHi, gLo;
        int n;
        int unsigned expN;
        expN = mul ? MULT_N : DIV_N;
        model(mul, sgn, a, b, eHi, eLo);
        run_op(mul, sgn, a, b, reqInRun, n, oldLo, gHi, gLo);
        checks++;
        if (n != int'(expN)) begin errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, n, expN); end
        checks++;
        if (oldLo !== mLo) begin errors++; $display("FAIL %s_lo_before_commit: got %h want %h", name, oldLo, mLo); end
        checks++;
        if (gHi !== eHi) begin errors++; $display("FAIL %s_hi: got %h want %h", name, gHi, eHi); end
        checks++;
        if (gLo !== eLo) begin errors++; $display("FAIL %s_lo: got %h want %h", name, gLo, eLo); end
        mHi = eHi; mLo = eLo;
    endtask

    task automatic test_mult_signed();
        test_op("mult_signed", 1, 1, 32'hFFFF_FFFE, 32'd3, 0);
        checks++;
        if (mHi !== 32'hFFFF_FFFF || mLo !== 32'hFFFF_FFFA) begin
            errors++; $display("FAIL mult_signed_ref: got %h_%h want ffffffff_fffffffa", mHi, mLo);
        end
    endtask

    task automatic test_divides();
        test_op("divu_7_2", 0, 0, 32'd7, 32'd2, 0);
        test_op("div_neg7_2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        test_op("div_ovf", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        checks++;
        if (mLo !== 32'h8000_0000 || mHi !== 32'h0) begin
            errors++; $display("FAIL div_ovf_ref: got %h_%h want 00000000_80000000", mHi, mLo);
        end
    endtask

    task automatic test_div_zero();
        write_hl(1, 32'h11);
        ReadHi = 1;
        #1 checks++;
        if (HLOut !== 32'h11) begin errors++; $display("FAIL mthi_visible: got %h want 11", HLOut); end
        ReadHi = 0;
        write_hl(0, 32'h22);
        #1 checks++;
        if (HLOut !== 32'h22) begin errors++; $display("FAIL mtlo_visible: got %h want 22", HLOut); end
        test_op("divu_by_zero", 0, 0, 32'h1234, 32'h0, 0);
    endtask

    task automatic test_req_suppress();
        isMU = 1; isSigned = 0; A = 32'hFFFF; B = 32'hFFFF; req = 1;
        @(posedge clk);
        @(negedge clk);
        isMU = 0; req = 0;
        WriteHL = 1; WriteHi = 1; A = 32'hDEAD; req = 1;
        @(posedge clk);
        @(negedge clk);
        WriteHL = 0; req = 0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL req_suppress_busy: got %b want 0", busy); end
            @(negedge clk);
        end
        ReadHi = 1;
        #1 checks++;
        if (HLOut !== mHi) begin errors++; $display("FAIL req_suppress_hi: got %h want %h", HLOut, mHi); end
        ReadHi = 0;
        #1 checks++;
        if (HLOut !== mLo) begin errors++; $display("FAIL req_suppress_lo: got %h want %h", HLOut, mLo); end
    endtask

    task automatic test_back_to_back();
        test_op("b2b_first", 1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        test_op("b2b_second", 1, 1, 32'h8000_0000, 32'h8000_0000, 0);
        test_op("b2b_third", 0, 1, 32'd100, 32'hFFFF_FFF9, 1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 4) == 0) write_hl(1'($urandom_range(0, 1)), $urandom);
            test_op("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b,
                    1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid();
        write_hl(1, 32'hAA);
        write_hl(0, 32'hBB);
        isDI = 1; isSigned = 0; A = 32'd50; B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        isDI = 0;
        repeat (2) @(negedge clk);
        reset_n = 0;
        #1 checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        ReadHi = 1;
        #1 checks++;
        if (HLOut !== 32'h0) begin errors++; $display("FAIL reset_mid_hi: got %h want 0", HLOut); end
        ReadHi = 0;
        #1 checks++;
        if (HLOut !== 32'h0) begin errors++; $display("FAIL reset_mid_lo: got %h want 0", HLOut); end
        @(negedge clk);
        reset_n = 1;
        mHi = 0; mLo = 0;
        repeat (DIV_N + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || HLOut !== 32'h0) begin
            errors++; $display("FAIL reset_mid_discard: busy=%b lo=%h want busy=0 lo=0", busy, HLOut);
        end
    endtask

    initial begin
        A = 0; B = 0; isMU = 0; isDI = 0; isSigned = 0;
        WriteHL = 0; WriteHi = 0; ReadHi = 0; req = 0; reset_n = 0;
        @(negedge clk);
        test_reset();
        test_mult_signed();
        test_divides();
        test_div_zero();
        test_req_suppress();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
